// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control unit of the multi-cycle MIPS CPU. Steps each instruction
// through IF / ID / EXE / MEM / WB. Every datapath strobe is a
// combinational decode of the registered state, the opcode and the ALU
// flags. The only flop is the state register.
//
// Ports
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous, active-low reset (forces state = IF)
//   opcode     in   instr[31:26] from the IR, stable from ID onward
//   zero       in   ALU result == 0 (used by beq/bne)
//   sign       in   ALU result bit 31 (no current instruction needs it)
//   PCWre      out  PC write enable, high in the last cycle of an instruction
//   IRWre      out  instruction register load (IF only)
//   InsMemRW   out  instruction memory read (IF only)
//   ExtSel     out  1 = sign-extend immediate, 0 = zero-extend
//   ALUSrcA    out  1 = shamt, 0 = rs
//   ALUSrcB    out  1 = extended immediate, 0 = rt
//   ALUOp      out  000 add, 001 sub, 010 and, 011 or, 100 signed slt
//   RegDst     out  00 $31, 01 rt, 10 rd (11 is never driven)
//   RegWre     out  register file write enable
//   WrRegDSrc  out  0 = PC+4 (jal), 1 = DB bus
//   mRD        out  data memory read
//   mWR        out  data memory write
//   DBDataSrc  out  0 = ALU result, 1 = memory data
//   PCSrc      out  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target
//   state      out  current state, for debug
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            sign,
  output logic            PCWre,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic            ExtSel,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic [1:0]      RegDst,
  output logic            RegWre,
  output logic            WrRegDSrc,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic [1:0]      PCSrc,
  output logic [ST_W-1:0] state
);

  // State encoding
  localparam logic [ST_W-1:0] S_IF     = 3'b000;
  localparam logic [ST_W-1:0] S_ID     = 3'b001;
  localparam logic [ST_W-1:0] S_EXE_LS = 3'b010;
  localparam logic [ST_W-1:0] S_MEM    = 3'b011;
  localparam logic [ST_W-1:0] S_WB_LD  = 3'b100;
  localparam logic [ST_W-1:0] S_EXE_BR = 3'b101;
  localparam logic [ST_W-1:0] S_EXE_AL = 3'b110;
  localparam logic [ST_W-1:0] S_WB_AL  = 3'b111;

  // Opcodes
  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  // Opcode class decode
  logic is_rtype;
  logic is_itype;
  logic is_alu;
  logic is_sw;
  logic is_lw;
  logic is_br;
  logic is_j;
  logic is_jal;
  logic is_jr;
  logic is_halt;
  logic br_taken;
  logic [2:0] alu_op;

  // The sign flag belongs to the ALU flag bundle but no supported
  // instruction consumes it yet.
  logic sign_unused;
  assign sign_unused = sign;

  assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_SLT);
  assign is_itype = (opcode == OP_ADDIU) || (opcode == OP_ORI);
  assign is_alu   = is_rtype || is_itype;
  assign is_sw    = (opcode == OP_SW);
  assign is_lw    = (opcode == OP_LW);
  assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jr    = (opcode == OP_JR);
  assign is_halt  = (opcode == OP_HALT);

  // beq branches on zero, bne on not-zero.
  assign br_taken = ((opcode == OP_BEQ) && zero) ||
                    ((opcode == OP_BNE) && !zero);

  // ALU function for the arithmetic/logic group; addiu reuses add.
  always_comb begin
    alu_op = 3'b000;
    case (opcode)
      OP_SUB:  alu_op = 3'b001;
      OP_AND:  alu_op = 3'b010;
      OP_ORI:  alu_op = 3'b011;
      OP_SLT:  alu_op = 3'b100;
      default: alu_op = 3'b000;
    endcase
  end

  // Next-state and output decode. PCWre is raised exactly in the cycle
  // whose successor is IF, so the PC advances once per instruction.
  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegDst    = 2'b00;
    RegWre    = 1'b0;
    WrRegDSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;

    case (state_q)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
        state_d  = S_ID;
      end

      S_ID: begin
        if (is_alu) begin
          state_d = S_EXE_AL;
        end else if (is_sw || is_lw) begin
          state_d = S_EXE_LS;
        end else if (is_br) begin
          state_d = S_EXE_BR;
        end else if (is_halt) begin
          // Halt parks in ID with every strobe low until Reset.
          state_d = S_ID;
        end else begin
          // j / jal / jr / undefined opcodes finish in ID.
          state_d = S_IF;
          PCWre   = 1'b1;
          if (is_j || is_jal) begin
            PCSrc = 2'b11;
          end else if (is_jr) begin
            PCSrc = 2'b10;
          end
          // jal links PC+4 into $31 (RegDst 00, WrRegDSrc 0).
          if (is_jal) begin
            RegWre = 1'b1;
          end
        end
      end

      S_EXE_AL: begin
        ALUOp   = alu_op;
        ALUSrcB = is_itype;
        ExtSel  = (opcode == OP_ADDIU);
        state_d = S_WB_AL;
      end

      S_WB_AL: begin
        ALUOp     = alu_op;
        ALUSrcB   = is_itype;
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = is_itype ? 2'b01 : 2'b10;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end

      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        state_d = S_MEM;
      end

      S_MEM: begin
        // Address computation held stable while memory is accessed.
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (is_lw) begin
          mRD     = 1'b1;
          state_d = S_WB_LD;
        end else begin
          mWR     = is_sw;
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end

      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        PCWre     = 1'b1;
        state_d   = S_IF;
      end

      S_EXE_BR: begin
        ALUOp   = 3'b001;
        ExtSel  = 1'b1;
        PCWre   = 1'b1;
        PCSrc   = br_taken ? 2'b01 : 2'b00;
        state_d = S_IF;
      end

      default: begin
        state_d = S_IF;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
